// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch 7-segment display path.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package stopwatch_pkg;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      DIG_SEC_O = 2'd0,
      DIG_SEC_T = 2'd1,
      DIG_MIN_O = 2'd2,
      DIG_MIN_T = 2'd3
   } dig_idx_t;

   // Splits a 0..59 value into {tens, ones}; anything larger yields 4'hF twice,
   // which the decoder renders as a dash.
   function automatic logic [7:0] split_bcd(input logic [5:0] v);
      logic [5:0] tens;
      logic [5:0] ones;
      logic [7:0] result;
      tens = v / 6'd10;
      ones = v % 6'd10;
      if (v >= 6'd60) begin
         result = 8'hFF;
      end else begin
         result = {tens[3:0], ones[3:0]};
      end
      return result;
   endfunction

endpackage

// File: rtl/stopwatch_display_seg7_decode.sv
// Combinational BCD to active-low 7-segment lookup; codes 10-15 show a dash.
module seg7_decode
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // BCD digit lookup
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_DIGIT[0];
         4'd1:    seg = SEG_DIGIT[1];
         4'd2:    seg = SEG_DIGIT[2];
         4'd3:    seg = SEG_DIGIT[3];
         4'd4:    seg = SEG_DIGIT[4];
         4'd5:    seg = SEG_DIGIT[5];
         4'd6:    seg = SEG_DIGIT[6];
         4'd7:    seg = SEG_DIGIT[7];
         4'd8:    seg = SEG_DIGIT[8];
         4'd9:    seg = SEG_DIGIT[9];
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/stopwatch_display.sv
// Time-multiplexed MM.SS driver for a 4-digit common-anode display with adjust blink.
// Optional macro STOPWATCH_DISPLAY_DP_EN lights the decimal point after the minutes.
module stopwatch_display
   import stopwatch_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic       adj,
   input  logic       sel,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [SCAN_W-1:0]  scan_cnt_r;
   dig_idx_t           idx_r;
   logic [11:0]        snap_r;
   logic [BLINK_W-1:0] blink_cnt_r;
   logic               phase_on_r;
   logic               live_r;
   logic [3:0]         an_r;
   logic [6:0]         seg_r;
   logic               dp_r;

   logic               frame_start_s;
   logic [11:0]        snap_view_s;
   logic [7:0]         min_bcd_s;
   logic [7:0]         sec_bcd_s;
   logic [3:0]         bcd_s;
   logic [3:0]         an_s;
   logic               field_sec_s;
   logic               blank_s;
   logic               dp_s;
   logic [6:0]         seg_dec_s;

   // The frame's first digit decodes the value being captured this very cycle,
   // so no digit of a frame ever shows the previous count.
   assign frame_start_s = (scan_cnt_r == {SCAN_W{1'b0}}) && (idx_r == DIG_MIN_T);
   assign snap_view_s   = frame_start_s ? {min, sec} : snap_r;

   seg7_decode u_dec (
      .bcd (bcd_s),
      .seg (seg_dec_s)
   );

   // Digit select, field blanking and decimal point for the active slot
   always_comb begin
      min_bcd_s   = split_bcd(snap_view_s[11:6]);
      sec_bcd_s   = split_bcd(snap_view_s[5:0]);
      bcd_s       = 4'hF;
      an_s        = 4'b1111;
      field_sec_s = 1'b0;
      blank_s     = 1'b0;
      dp_s        = 1'b1;
      case (idx_r)
         DIG_MIN_T: begin bcd_s = min_bcd_s[7:4]; an_s = 4'b0111; field_sec_s = 1'b0; end
         DIG_MIN_O: begin bcd_s = min_bcd_s[3:0]; an_s = 4'b1011; field_sec_s = 1'b0; end
         DIG_SEC_T: begin bcd_s = sec_bcd_s[7:4]; an_s = 4'b1101; field_sec_s = 1'b1; end
         DIG_SEC_O: begin bcd_s = sec_bcd_s[3:0]; an_s = 4'b1110; field_sec_s = 1'b1; end
         default:   begin bcd_s = 4'hF;           an_s = 4'b1111; field_sec_s = 1'b0; end
      endcase
      if (adj && !phase_on_r && (field_sec_s == sel)) begin
         blank_s = 1'b1;
      end else begin
         blank_s = 1'b0;
      end
`ifdef STOPWATCH_DISPLAY_DP_EN
      if (idx_r == DIG_MIN_O) begin
         dp_s = 1'b0;
      end else begin
         dp_s = 1'b1;
      end
`else
      dp_s = 1'b1;
`endif
   end

   // Scan counter, digit index and once-per-frame snapshot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt_r <= {SCAN_W{1'b0}};
         idx_r      <= DIG_MIN_T;
         snap_r     <= 12'd0;
         live_r     <= 1'b0;
      end else begin
         live_r <= 1'b1;
         if (frame_start_s) begin
            snap_r <= {min, sec};
         end
         if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= {SCAN_W{1'b0}};
            idx_r      <= dig_idx_t'(idx_r - 2'd1);
         end else begin
            scan_cnt_r <= scan_cnt_r + {{(SCAN_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Blink timebase, parked at counter 0 / phase on outside adjust mode
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blink_cnt_r <= {BLINK_W{1'b0}};
         phase_on_r  <= 1'b1;
      end else if (!adj) begin
         blink_cnt_r <= {BLINK_W{1'b0}};
         phase_on_r  <= 1'b1;
      end else if (blink_cnt_r == BLINK_LAST) begin
         blink_cnt_r <= {BLINK_W{1'b0}};
         phase_on_r  <= ~phase_on_r;
      end else begin
         blink_cnt_r <= blink_cnt_r + {{(BLINK_W-1){1'b0}}, 1'b1};
      end
   end

   // Registered display outputs; the cycle after reset release stays dark
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an_r  <= 4'b1111;
         seg_r <= SEG_BLANK;
         dp_r  <= 1'b1;
      end else if (!live_r) begin
         an_r  <= 4'b1111;
         seg_r <= SEG_BLANK;
         dp_r  <= 1'b1;
      end else begin
         an_r  <= an_s;
         seg_r <= blank_s ? SEG_BLANK : seg_dec_s;
         dp_r  <= dp_s;
      end
   end

   assign an  = an_r;
   assign seg = seg_r;
   assign dp  = dp_r;

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display (SCAN_DIV=4, BLINK_DIV=32); the driver
// queues one expected output per clock and a monitor pops and compares them.
module tb_stopwatch_display;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic [3:0] tag;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [5:0] sec;
   logic [5:0] min;
   logic       adj;
   logic       sel;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   exp_t       q[$];
   int         vectors;
   int         miscompares;
   int         n;
   int         adj_k;
   logic [5:0] s_min;
   logic [5:0] s_sec;
   logic [6:0] seg_tab [0:9];
   string      tag_name [0:6];

   stopwatch_display #(.SCAN_DIV(4), .BLINK_DIV(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sec   (sec),
      .min   (min),
      .adj   (adj),
      .sel   (sel),
      .an    (an),
      .seg   (seg),
      .dp    (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic dp_for(input logic [3:0] a);
`ifdef STOPWATCH_DISPLAY_DP_EN
      return (a == 4'b1011) ? 1'b0 : 1'b1;
`else
      return 1'b1;
`endif
   endfunction

   // Queue the expected output for the coming edge (reference view or a literal), then clock
   task automatic step(input logic use_lit, input logic [3:0] lan, input logic [6:0] lseg,
                       input logic [3:0] tag);
      exp_t       e;
      int         idx;
      int         v;
      logic       blank;
      e = '0;
      if (!rst_n) begin
         e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
         n = 0; adj_k = 0;
      end else begin
         n++;
         if ((n - 1) % 16 == 0) begin
            s_min = min; s_sec = sec;
         end
         if (n == 1) begin
            e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
         end else begin
            idx  = 3 - (((n - 1) / 4) % 4);
            v    = (idx >= 2) ? int'(s_min) : int'(s_sec);
            e.an = 4'b1111;
            e.an[idx] = 1'b0;
            if (v >= 60) e.seg = 7'b0111111;
            else e.seg = seg_tab[(idx % 2 == 1) ? (v / 10) : (v % 10)];
            blank = adj && (((adj_k / 32) % 2) == 1) && (sel ? (idx < 2) : (idx >= 2));
            if (blank) e.seg = 7'b1111111;
            e.dp = dp_for(e.an);
         end
         if (adj) adj_k++;
         else adj_k = 0;
      end
      if (use_lit) begin
         e.an = lan; e.seg = lseg; e.dp = dp_for(lan);
      end
      e.tag = tag;
      q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int cnt, input logic [3:0] tag);
      for (int i = 0; i < cnt; i++) step(1'b0, 4'b0, 7'b0, tag);
   endtask

   task automatic lit(input int cnt, input logic [3:0] lan, input logic [6:0] lseg,
                      input logic [3:0] tag);
      for (int i = 0; i < cnt; i++) step(1'b1, lan, lseg, tag);
   endtask

   // Monitor: one registered output per clock, compared just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
               miscompares++;
               $display("FAIL %s @%0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                        tag_name[e.tag], $time, an, seg, dp, e.an, e.seg, e.dp);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      tag_name = '{"reset", "frame", "coherence", "range", "blink", "midreset", "drain"};
      vectors = 0; miscompares = 0; n = 0; adj_k = 0; s_min = 6'd0; s_sec = 6'd0;
      rst_n = 1'b0; min = 6'd12; sec = 6'd34; adj = 1'b0; sel = 1'b0;

      // Reset, then the first frame of 12:34
      lit(3, 4'b1111, 7'b1111111, 4'd0);
      rst_n = 1'b1;
      lit(1, 4'b1111, 7'b1111111, 4'd0);
      lit(3, 4'b0111, 7'b1111001, 4'd0);
      lit(4, 4'b1011, 7'b0100100, 4'd0);
      lit(4, 4'b1101, 7'b0110000, 4'd0);
      lit(4, 4'b1110, 7'b0011001, 4'd0);

      // Second frame: sec changes while index 1 is lit, must not show until next frame
      run(8, 4'd1);
      sec = 6'd35;
      lit(4, 4'b1101, 7'b0110000, 4'd2);
      lit(4, 4'b1110, 7'b0011001, 4'd2);
      lit(4, 4'b0111, 7'b1111001, 4'd2);
      lit(4, 4'b1011, 7'b0100100, 4'd2);
      lit(4, 4'b1101, 7'b0110000, 4'd2);
      lit(4, 4'b1110, 7'b0010010, 4'd2);

      // Out-of-range minutes render as dashes
      min = 6'd61; sec = 6'd59;
      lit(4, 4'b0111, 7'b0111111, 4'd3);
      lit(4, 4'b1011, 7'b0111111, 4'd3);
      lit(4, 4'b1101, 7'b0010010, 4'd3);
      lit(4, 4'b1110, 7'b0010000, 4'd3);

      // Blink seconds, then minutes, then restart blinking from phase on
      min = 6'd5; sec = 6'd9; adj = 1'b1; sel = 1'b1;
      run(128, 4'd4);
      sel = 1'b0;
      run(64, 4'd4);
      adj = 1'b0;
      run(16, 4'd4);
      adj = 1'b1;
      run(48, 4'd4);
      adj = 1'b0;

      // Reset while index 1 is lit, scan must restart at index 3
      guard = 0;
      while ((3 - ((n / 4) % 4)) != 1 && guard < 32) begin
         run(1, 4'd5);
         guard++;
      end
      run(1, 4'd5);
      rst_n = 1'b0;
      lit(1, 4'b1111, 7'b1111111, 4'd5);
      rst_n = 1'b1;
      lit(1, 4'b1111, 7'b1111111, 4'd5);
      lit(3, 4'b0111, 7'b1000000, 4'd5);
      lit(4, 4'b1011, 7'b0010010, 4'd5);
      run(24, 4'd5);

      #4;
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected outputs left unchecked, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Downstream stage of the stopwatch counter. Takes the binary minutes/seconds values and drives a 4-digit common-anode, time-multiplexed 7-segment display as MM.SS.

- Scans one digit per slot and splits each value into tens and ones.
- In adjust mode, blinks whichever field is selected.
- Snapshots the counter value once per scan frame, so a frame never mixes two counts.

## Interface
Parameters:
- SCAN_DIV, 100000: clock cycles each digit is lit (≥2).
- BLINK_DIV, 25000000: clock cycles per blink half-period (≥2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- sec  input  6  seconds from counter; legal 0–59.
- min  input  6  minutes from counter; legal 0–59.
- adj  input  1  adjust mode active.
- sel  input  1  adjust field: 1 = seconds, 0 = minutes.
- an  output  4  digit enables, active-low; an[3] = min tens, an[0] = sec ones.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

## Operation
Scan counter:
- Counts 0..SCAN_DIV-1.
- On wrap, the digit index steps 3→2→1→0→3.

Frame snapshot:
- Taken when the scan counter is 0 and the index is 3.
- Loads {min, sec} into the snapshot register. Inputs are ignored at all other times.

Decode per field (6-bit value v):
- v ≤ 59: tens = v/10 (0–5), ones = v%10.
- v ≥ 60: both digits show a dash, seg = 7'b0111111. Upstream adjust can produce 60/61.

Segment codes:
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
- 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- blank = 1111111

Leading zeros are shown (e.g. 00.07).

Blink:
- The blink counter runs 0..BLINK_DIV-1 and toggles the phase (on/off) on wrap.
- It runs only while adj = 1.
- When adj = 0, the counter is held at 0 and the phase is held at on.
- When adj rises, blinking starts from phase on, counter 0.
- With adj = 1 and phase off, both digits of the selected field output blank. The other field displays normally.
- sel changes take effect on the next registered output. They do not restart the blink.

## Timing
Reset (rst_n = 0 at a clock edge) sets:
- an = 4'b1111, seg = 7'b1111111, dp = 1
- index = 3, scan counter = 0, blink counter = 0, phase = on, snapshot = 0

Reset mid-scan aborts the frame. The same reset values apply on any cycle.

Outputs are registered: an/seg/dp are a one-cycle-late decode of index, snapshot and blink state.
- Cycle 1 after reset release: snapshot loads, outputs still blank.
- Cycle 2: an = 0111, showing the new snapshot's min tens.

Input-to-display latency is up to 4·SCAN_DIV+1 cycles, because inputs are sampled only at frame start.

Exactly one an bit is low at any time after cycle 1. No overlap or gap cycles.

## Configuration
STOPWATCH_DISPLAY_DP_EN:
- Defined: dp = 0 (lit) whenever index = 2 (min ones), separating MM.SS. It is not blanked by blink.
- Undefined: dp is constant 1. The port remains present.

## Structure
Package stopwatch_pkg holds:
- the segment code constants (SEG_DIGIT[0:9], SEG_BLANK, SEG_DASH)
- the 2-bit digit index type
- digit index constants DIG_MIN_T..DIG_SEC_O

One sub-module, seg7_decode: combinational 4-bit BCD to 7-segment lookup. Codes 10–15 map to SEG_DASH.

## Test plan
Bench uses SCAN_DIV = 4, BLINK_DIV = 32.

- Reset: hold rst_n = 0 for 3 cycles, then release with min = 12, sec = 34. Required:
  - cycle 1: an = 1111
  - cycle 2: an = 0111, seg = 1111001
  - then an = 1011/0100100, an = 1101/0110000, an = 1110/0011001, each for 4 cycles
- Frame coherence: change sec from 34 to 35 mid-frame (index = 1). Current frame still shows 4. The next frame shows 5 (0010010).
- Out of range: min = 61, sec = 59. Required: digits 3/2 show 0111111; digits 1/0 show 0010010/0010000.
- Blink: adj = 1, sel = 1, min = 5, sec = 9.
  - Seconds digits are blank for 32 of every 64 cycles. The minutes digits never blank.
  - Flip to sel = 0: minutes blank, seconds steady.
  - adj 0→1: the first 32 cycles are visible.
- Reset mid-frame: rst_n = 0 at index = 1. Next cycle an = 1111, seg = 1111111. After release, scan restarts at index 3.
- DP (macro on/off): with the macro defined, dp = 0 only while an = 1011. With it undefined, dp = 1 always.
